ifu_fetch: RTL and testbench

Instruction fetch stage directly downstream of the branch/PC unit. Takes the current PC and issues one instruction-memory request per instruction, then waits for the response. It buffers the returned instruction with its PC and hands the pair to decode over a valid/ready handshake. A redirect (flush) from the branch unit kills any in-flight or buffered instruction so that only correct-path instructions reach decode.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/stl_reg.sv | 22 ++
 rtl/ifu_fetch.sv | 122 ++++++++++++
 tb/tb_ifu_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch FSM encoding and the bubble instruction shown to decode when nothing is valid.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      OUT
   } fetch_state_e;

   // Shown on o_inst whenever decode has nothing valid (addi x0,x0,0).
   localparam logic [31:0] KILL_INST = 32'h0000_0013;

endpackage

// File: rtl/stl_reg.sv
// Generic async-reset register with load enable.
// Zero latency beyond one clock; no flow control of its own.
module stl_reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_q <= RESET_VAL;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: one imem request per instruction, buffers inst+PC for decode, flush kills wrong path.
// Best case 3 cycles per instruction; request held until accepted, output held while decode stalls.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module ifu_fetch #(
   parameter int                    CPU_WIDTH  = `CPU_WIDTH,
   parameter int                    INST_WIDTH = 32,
   parameter logic [INST_WIDTH-1:0] KILL_INST  = INST_WIDTH'(ifu_pkg::KILL_INST)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [CPU_WIDTH-1:0]  i_pc,
   input  logic                  i_flush,
   output logic                  o_pre_ready,
   output logic                  o_imem_req_valid,
   input  logic                  i_imem_req_ready,
   output logic [CPU_WIDTH-1:0]  o_imem_addr,
   input  logic                  i_imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] i_imem_rsp_data,
   output logic                  o_post_valid,
   input  logic                  i_post_ready,
   output logic [INST_WIDTH-1:0] o_inst,
   output logic [CPU_WIDTH-1:0]  o_pc
);

   import ifu_pkg::*;

   fetch_state_e          state_q;
   fetch_state_e          state_d;
   logic [CPU_WIDTH-1:0]  pc_q;
   logic [CPU_WIDTH-1:0]  pc_d;
   logic                  pc_en;
   logic [INST_WIDTH-1:0] inst_q;
   logic [INST_WIDTH-1:0] inst_d;
   logic                  inst_en;
   logic                  kill_q;
   logic                  kill_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      pc_en   = 1'b0;
      pc_d    = i_pc;
      inst_en = 1'b0;
      inst_d  = i_imem_rsp_data;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (i_imem_req_ready) begin
               // A flush in the handshake cycle means this response is already wrong-path.
               state_d = WAIT;
               pc_en   = 1'b1;
               kill_d  = i_flush;
            end
         end
         WAIT: begin
            if (i_imem_rsp_valid) begin
               if (kill_q || i_flush) begin
                  state_d = REQ;
                  kill_d  = 1'b0;
               end else begin
                  state_d = OUT;
                  inst_en = 1'b1;
               end
            end else if (i_flush) begin
               kill_d = 1'b1;
            end
         end
         OUT: begin
            if (i_flush || i_post_ready) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_imem_req_valid = (state_q == REQ);
      o_imem_addr      = i_pc;
      o_pre_ready      = ((state_q == REQ) && i_imem_req_ready) || i_flush;
      // A flush in OUT only changes state, so o_post_valid stays high this cycle and drops the next.
      o_post_valid     = (state_q == OUT);
      o_inst           = (state_q == OUT) ? inst_q : KILL_INST;
      o_pc             = pc_q;
   end

   stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_pc_reg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (pc_en),
      .i_d   (pc_d),
      .o_q   (pc_q)
   );

   stl_reg #(.WIDTH(INST_WIDTH), .RESET_VAL(KILL_INST)) u_inst_reg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (inst_en),
      .i_d   (inst_d),
      .o_q   (inst_q)
   );

   stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_kill_reg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (1'b1),
      .i_d   (kill_d),
      .o_q   (kill_q)
   );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: cycle table of inputs/expected outputs plus a mid-transaction reset sequence.
module tb_ifu_fetch;

   localparam logic [63:0] A  = 64'h8000_0000;
   localparam logic [63:0] T1 = 64'h8000_0040;
   localparam logic [63:0] B  = 64'h8000_0100;
   localparam logic [63:0] T2 = 64'h8000_0300;
   localparam logic [63:0] T3 = 64'h8000_0400;
   localparam logic [63:0] T4 = 64'h8000_0500;
   localparam logic [63:0] T5 = 64'h8000_0600;
   localparam logic [31:0] K  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] pc = A;
   logic        flush = 1'b0;
   logic        pre_ready;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [63:0] addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        post_valid;
   logic        post_ready = 1'b1;
   logic [31:0] inst;
   logic [63:0] opc;

   int total = 0;
   int bad   = 0;
   int outst = 0;

   always #5 clk = ~clk;

   ifu_fetch #(.CPU_WIDTH(64), .INST_WIDTH(32), .KILL_INST(32'h0000_0013)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_pc             (pc),
      .i_flush          (flush),
      .o_pre_ready      (pre_ready),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (req_ready),
      .o_imem_addr      (addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .o_post_valid     (post_valid),
      .i_post_ready     (post_ready),
      .o_inst           (inst),
      .o_pc             (opc)
   );

   // Protocol monitor: a response is only legal while a request is outstanding.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         outst <= 0;
      end else begin
         if (rsp_valid) begin
            total++;
            if (outst == 0) begin
               bad++;
               $display("FAIL rsp_protocol: response with outstanding=%0d, required 1", outst);
            end
            outst <= 0;
         end
         if (req_valid && req_ready) outst <= 1;
      end
   end

   typedef struct {
      logic [63:0] pc;
      logic        fl;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        pr;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_pre;
      logic        e_pv;
      logic [31:0] e_inst;
      logic [63:0] e_pc;
   } vec_t;

   vec_t v[64];
   int   n = 0;

   task automatic add(input logic [63:0] p, input logic f, input logic r, input logic rv,
                      input logic [31:0] rd, input logic pr, input logic erv,
                      input logic [63:0] ea, input logic epre, input logic epv,
                      input logic [31:0] ei, input logic [63:0] ep);
      v[n] = '{p, f, r, rv, rd, pr, erv, ea, epre, epv, ei, ep};
      n++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic erv, input logic [63:0] ea,
                           input logic epre, input logic epv, input logic [31:0] ei,
                           input logic [63:0] ep);
      chk({tag, ".req_valid"}, {63'd0, req_valid}, {63'd0, erv});
      if (erv) chk({tag, ".addr"}, addr, ea);
      chk({tag, ".pre_ready"}, {63'd0, pre_ready}, {63'd0, epre});
      chk({tag, ".post_valid"}, {63'd0, post_valid}, {63'd0, epv});
      chk({tag, ".inst"}, {32'd0, inst}, {32'd0, ei});
      chk({tag, ".pc"}, opc, ep);
   endtask

   initial begin
      // pc, fl, rdy, rv, rd, pr | e_rv, e_addr, e_pre, e_pv, e_inst, e_pc
      add(A,    0,1,0,32'h0,1,        0,0,   0,0,K,           0);     // IDLE after reset
      add(A,    0,1,0,32'h0,1,        1,A,   1,0,K,           0);     // first request
      add(A+4,  0,1,1,32'h93,1,       0,0,   0,0,K,           A);     // response next cycle
      for (int i = 0; i < 5; i++)
         add(A+4,0,1,0,32'h0,0,       0,0,   0,1,32'h93,      A);     // decode stall
      add(A+4,  0,1,0,32'h0,1,        0,0,   0,1,32'h93,      A);     // transfer
      for (int i = 0; i < 4; i++)
         add(A+4,0,0,0,32'h0,1,       1,A+4, 0,0,K,           A);     // memory backpressure
      add(A+4,  0,1,0,32'h0,1,        1,A+4, 1,0,K,           A);
      add(A+8,  0,1,0,32'h0,1,        0,0,   0,0,K,           A+4);
      add(A+8,  0,1,1,32'h113,1,      0,0,   0,0,K,           A+4);
      add(A+8,  1,1,0,32'h0,1,        0,0,   1,1,32'h113,     A+4);   // flush in OUT with ready
      add(T1,   0,1,0,32'h0,1,        1,T1,  1,0,K,           A+4);   // post_valid gone
      add(T1+4, 1,1,0,32'h0,1,        0,0,   1,0,K,           T1);    // flush in WAIT
      add(B,    0,1,0,32'h0,1,        0,0,   0,0,K,           T1);
      add(B,    0,1,1,32'hdead_beef,1,0,0,   0,0,K,           T1);    // stale response dropped
      add(B,    0,1,0,32'h0,1,        1,B,   1,0,K,           T1);
      add(B+4,  0,1,1,32'h213,1,      0,0,   0,0,K,           B);
      add(B+4,  0,1,0,32'h0,1,        0,0,   0,1,32'h213,     B);
      add(B+4,  1,1,0,32'h0,1,        1,B+4, 1,0,K,           B);     // flush with handshake
      add(T2,   0,1,1,32'hbad0_0001,1,0,0,   0,0,K,           B+4);   // killed response
      add(T2,   0,1,0,32'h0,1,        1,T2,  1,0,K,           B+4);
      add(T2+4, 0,1,0,32'h0,1,        0,0,   0,0,K,           T2);    // only one request to target
      add(T2+4, 0,1,1,32'h313,1,      0,0,   0,0,K,           T2);
      add(T2+4, 0,1,0,32'h0,1,        0,0,   0,1,32'h313,     T2);
      add(T2+4, 0,1,0,32'h0,1,        1,T2+4,1,0,K,           T2);
      add(T2+8, 1,1,1,32'hbad0_0002,1,0,0,   1,0,K,           T2+4);  // flush with response
      add(T3,   0,1,0,32'h0,1,        1,T3,  1,0,K,           T2+4);
      add(T3+4, 0,1,1,32'h413,1,      0,0,   0,0,K,           T3);
      add(T3+4, 0,1,0,32'h0,0,        0,0,   0,1,32'h413,     T3);
      add(T3+4, 0,1,0,32'h0,1,        0,0,   0,1,32'h413,     T3);
      add(T3+4, 1,0,0,32'h0,1,        1,T3+4,1,0,K,           T3);    // flush in REQ, no handshake
      add(T4,   0,1,0,32'h0,1,        1,T4,  1,0,K,           T3);
      add(T4+4, 0,1,1,32'h513,1,      0,0,   0,0,K,           T4);
      add(T4+4, 0,1,0,32'h0,1,        0,0,   0,1,32'h513,     T4);

      @(negedge clk);
      #1;
      chk_outs("reset", 0, 0, 0, 0, K, 0);
      flush = 1'b1;
      #1;
      chk("reset.flush_pass", {63'd0, pre_ready}, 64'd1);
      flush = 1'b0;
      #1;
      rst = 1'b0;

      for (int i = 0; i < n; i++) begin
         pc         = v[i].pc;
         flush      = v[i].fl;
         req_ready  = v[i].rdy;
         rsp_valid  = v[i].rv;
         rsp_data   = v[i].rd;
         post_ready = v[i].pr;
         #1;
         chk_outs($sformatf("vec%0d", i), v[i].e_rv, v[i].e_addr, v[i].e_pre,
                  v[i].e_pv, v[i].e_inst, v[i].e_pc);
         @(negedge clk);
      end

      // Reset in the middle of a transaction abandons the outstanding request.
      pc = T5; flush = 1'b0; req_ready = 1'b1; rsp_valid = 1'b0; post_ready = 1'b1;
      #1;
      chk_outs("mid.req", 1, T5, 1, 0, K, T4);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_outs("mid.reset", 0, 0, 0, 0, K, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_outs("mid.idle", 0, 0, 0, 0, K, 0);
      @(negedge clk);
      #1;
      chk_outs("mid.req2", 1, T5, 1, 0, K, 0);
      @(negedge clk);
      rsp_valid = 1'b1; rsp_data = 32'h613;
      #1;
      chk_outs("mid.wait", 0, 0, 0, 0, K, T5);
      @(negedge clk);
      rsp_valid = 1'b0;
      #1;
      chk_outs("mid.out", 0, 0, 0, 1, 32'h613, T5);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
